controle_execucao: RTL
======================

Name: controle_execucao

Overview:
- Multi-cycle sequencer for the 16x16 register bank (`memoria`).
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it.
- Drives the bank's async read addresses, computes the result in an internal ALU, and issues the synchronous write or bank clear.
- Sits between the instruction source (switches/ROM stepper) and `memoria`; also presents results to the display logic.

Parameters:
- CLEAR_ON_RESET, 1, when 1 `mem_ativar_clear` is asserted while `rst_n` is low, so reset also clears the bank.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- instr_valid  input  1  producer has an instruction on `instrucao`.
- instr_ready  output  1  controller can accept an instruction (high only in OCIOSO).
- instrucao  input  16  [15:13] op, [12:9] rd, [8:5] rs1, [4:1] rs2, [4:0] imm5, [8:0] imm9.
- mem_endereco_reg1  output  4  bank read address 1.
- mem_endereco_reg2  output  4  bank read address 2.
- mem_conteudo_reg1  input  16  bank read data 1 (combinational from address).
- mem_conteudo_reg2  input  16  bank read data 2.
- mem_endereco_escrita  output  4  bank write address.
- mem_conteudo_escrita  output  16  bank write data.
- mem_enable  output  1  bank write enable, one-cycle pulse.
- mem_ativar_clear  output  1  bank clear request.
- resultado  output  16  last result (write data or displayed register).
- resultado_valido  output  1  one-cycle pulse when `resultado` updates.
- opcode_atual  output  3  opcode of the instruction in flight (last accepted).
- ocupado  output  1  high whenever state != OCIOSO.

Behaviour:
- Opcodes:
  - 000 LOAD: rd <= sext(imm9).
  - 001 ADD: rd <= rs1 + rs2.
  - 010 ADDI: rd <= rs1 + sext(imm5).
  - 011 SUB: rd <= rs1 - rs2.
  - 100 SUBI: rd <= rs1 - sext(imm5).
  - 101 MUL: rd <= low 16 bits of rs1 * rs2.
  - 110 CLEAR: all registers <= 0.
  - 111 DISPLAY: resultado <= reg[rd]; no write.
- Arithmetic is 16-bit two's complement; wrap silently, no flags.
- FSM states: OCIOSO, LEITURA, EXECUTA, ESCRITA, LIMPEZA.
  - OCIOSO: instr_ready=1. On instr_valid&&instr_ready, latch instrucao into instr_reg and go to LEITURA.
  - LEITURA: read addresses come from instr_reg (rs1, rs2; DISPLAY puts rd on reg1). Register operands into op_a/op_b. Go to LIMPEZA if op=110, else EXECUTA.
  - EXECUTA: ALU result registered into res_reg. Go to ESCRITA.
  - ESCRITA: resultado<=res_reg and resultado_valido=1. For ops 000-101 only: mem_enable=1, mem_endereco_escrita=rd, mem_conteudo_escrita=res_reg. Go to OCIOSO.
  - LIMPEZA: mem_ativar_clear=1 for one cycle; resultado<=0, resultado_valido=1. Go to OCIOSO.
- Latency: for an accept at edge N, the bank write occurs at edge N+3. Throughput is one instruction per 4 cycles (CLEAR: 3).
- Back-to-back dependent instructions need no forwarding, because the write completes before the next LEITURA.
- instr_valid while busy is ignored. Producer must hold instrucao until the handshake.
- rd=0 is an ordinary writable register (no hardwired zero).
- mem_enable and mem_ativar_clear are never high together.
- Read address outputs hold their last value in OCIOSO.
- Reset (rst_n low at a posedge), including mid-operation:
  - state<=OCIOSO, instr_reg<=0, op_a/op_b/res_reg<=0, resultado<=0, opcode_atual<=0.
  - resultado_valido=0 and mem_enable=0; any pending write is aborted.
  - mem_ativar_clear = ~rst_n when CLEAR_ON_RESET=1, else 0 during reset.
  - instr_ready=0 during reset and 1 in the cycle after release.

Decomposition:
- Shared package/include holds:
  - opcode constants OP_LOAD..OP_DISPLAY.
  - state encoding (3-bit) ST_OCIOSO..ST_LIMPEZA.
  - instruction field bit positions.
- One sub-module: `ula`. It is combinational, with inputs op[2:0], a[15:0], b[15:0], imm[8:0] and output res[15:0]; sign extension happens inside it.
- FSM and handshake stay in `controle_execucao`.

Test Plan:
- Reset then 0x0205 (LOAD R1,5) -> mem_enable pulses 3 cycles after accept with addr 1, data 0x0005; resultado_valido pulses once.
- 0x05FD (LOAD R2,-3) then 0x2624 (ADD R3,R1,R2) -> write R3=0x0002; then 0xE600 (DISPLAY R3) -> resultado=0x0002, mem_enable stays 0.
- 0xA822 (MUL R4,R1,R1) -> R4=0x0019. SUB R7,R0,R1 with R0=0 -> R7=0xFFFB (wrap check).
- instr_valid held high with new instrucao during LEITURA/EXECUTA -> instr_ready=0, no acceptance; the held instruction is accepted exactly once on return to OCIOSO.
- 0xC000 (CLEAR) -> mem_ativar_clear high exactly one cycle, mem_enable 0; subsequent DISPLAY R4 -> resultado=0x0000.
- rst_n low during EXECUTA of an ADD -> no mem_enable pulse; state OCIOSO; mem_ativar_clear high during reset (CLEAR_ON_RESET=1); ocupado=0 after release.

Source files
------------

// File: rtl/controle_execucao_pkg.sv
// Shared definitions for the register-bank execution controller:
// opcodes, FSM state encoding, instruction field positions and sign-extension helpers.
package controle_execucao_pkg;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_ADD     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_SUB     = 3'd3,
        OP_SUBI    = 3'd4,
        OP_MUL     = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_DISPLAY = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_OCIOSO  = 3'd0,
        ST_LEITURA = 3'd1,
        ST_EXECUTA = 3'd2,
        ST_ESCRITA = 3'd3,
        ST_LIMPEZA = 3'd4
    } estado_t;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RD_MSB   = 12;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 5;
    localparam int RS2_MSB  = 4;
    localparam int RS2_LSB  = 1;
    localparam int IMM5_MSB = 4;
    localparam int IMM9_MSB = 8;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

// File: rtl/controle_execucao_ula.sv
// Combinational ALU for the execution controller; immediates are sign-extended here.
module ula
    import controle_execucao_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [8:0]  imm,
    output logic [15:0] res
);

    // Result select; DISPLAY passes the register read through on operand a
    always_comb begin
        res = 16'h0000;
        case (op)
            OP_LOAD:    res = sext9(imm);
            OP_ADD:     res = a + b;
            OP_ADDI:    res = a + sext5(imm[IMM5_MSB:0]);
            OP_SUB:     res = a - b;
            OP_SUBI:    res = a - sext5(imm[IMM5_MSB:0]);
            OP_MUL:     res = a * b;
            OP_CLEAR:   res = 16'h0000;
            OP_DISPLAY: res = a;
            default:    res = 16'h0000;
        endcase
    end

endmodule

// File: rtl/controle_execucao.sv
// Multi-cycle sequencer for the 16x16 register bank: accepts one instruction,
// reads operands, executes in the ALU and issues the bank write or clear.
module controle_execucao
    import controle_execucao_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instrucao,
    output logic [3:0]  mem_endereco_reg1,
    output logic [3:0]  mem_endereco_reg2,
    input  logic [15:0] mem_conteudo_reg1,
    input  logic [15:0] mem_conteudo_reg2,
    output logic [3:0]  mem_endereco_escrita,
    output logic [15:0] mem_conteudo_escrita,
    output logic        mem_enable,
    output logic        mem_ativar_clear,
    output logic [15:0] resultado,
    output logic        resultado_valido,
    output logic [2:0]  opcode_atual,
    output logic        ocupado
);

    estado_t     estado_r;
    estado_t     proximo_s;
    logic [15:0] instr_r;
    logic [15:0] op_a_r;
    logic [15:0] op_b_r;
    logic [15:0] res_r;
    logic [15:0] resultado_r;
    logic [3:0]  end1_r;
    logic [3:0]  end2_r;
    logic [15:0] ula_res_s;
    logic [2:0]  op_s;
    logic        grava_s;

    assign op_s = instr_r[OP_MSB:OP_LSB];

    ula u_ula (
        .op  (op_s),
        .a   (op_a_r),
        .b   (op_b_r),
        .imm (instr_r[IMM9_MSB:0]),
        .res (ula_res_s)
    );

    // Next-state decode
    always_comb begin
        proximo_s = estado_r;
        case (estado_r)
            ST_OCIOSO: begin
                if (instr_valid) begin
                    proximo_s = ST_LEITURA;
                end else begin
                    proximo_s = ST_OCIOSO;
                end
            end
            ST_LEITURA: begin
                if (op_s == OP_CLEAR) begin
                    proximo_s = ST_LIMPEZA;
                end else begin
                    proximo_s = ST_EXECUTA;
                end
            end
            ST_EXECUTA: proximo_s = ST_ESCRITA;
            ST_ESCRITA: proximo_s = ST_OCIOSO;
            ST_LIMPEZA: proximo_s = ST_OCIOSO;
            default:    proximo_s = ST_OCIOSO;
        endcase
    end

    // State, instruction latch, operand/result pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_r    <= ST_OCIOSO;
            instr_r     <= 16'h0000;
            op_a_r      <= 16'h0000;
            op_b_r      <= 16'h0000;
            res_r       <= 16'h0000;
            resultado_r <= 16'h0000;
            end1_r      <= 4'h0;
            end2_r      <= 4'h0;
        end else begin
            estado_r <= proximo_s;
            case (estado_r)
                ST_OCIOSO: begin
                    if (instr_valid) begin
                        instr_r <= instrucao;
                        // DISPLAY reads rd through port 1 so the ALU can pass it on
                        if (instrucao[OP_MSB:OP_LSB] == OP_DISPLAY) begin
                            end1_r <= instrucao[RD_MSB:RD_LSB];
                        end else begin
                            end1_r <= instrucao[RS1_MSB:RS1_LSB];
                        end
                        end2_r <= instrucao[RS2_MSB:RS2_LSB];
                    end
                end
                ST_LEITURA: begin
                    op_a_r <= mem_conteudo_reg1;
                    op_b_r <= mem_conteudo_reg2;
                end
                ST_EXECUTA: res_r       <= ula_res_s;
                ST_ESCRITA: resultado_r <= res_r;
                ST_LIMPEZA: resultado_r <= 16'h0000;
                default:    resultado_r <= resultado_r;
            endcase
        end
    end

    assign grava_s = (estado_r == ST_ESCRITA) && (op_s != OP_DISPLAY) && (op_s != OP_CLEAR);

    // Strobes are gated by rst_n so an in-flight write is dropped the moment reset asserts
    always_comb begin
        instr_ready      = rst_n && (estado_r == ST_OCIOSO);
        mem_enable       = rst_n && grava_s;
        resultado_valido = rst_n && ((estado_r == ST_ESCRITA) || (estado_r == ST_LIMPEZA));
        if (!rst_n) begin
            mem_ativar_clear = CLEAR_ON_RESET;
        end else begin
            mem_ativar_clear = (estado_r == ST_LIMPEZA);
        end
    end

    assign mem_endereco_reg1    = end1_r;
    assign mem_endereco_reg2    = end2_r;
    assign mem_endereco_escrita = instr_r[RD_MSB:RD_LSB];
    assign mem_conteudo_escrita = res_r;
    assign resultado            = resultado_r;
    assign opcode_atual         = op_s;
    assign ocupado              = (estado_r != ST_OCIOSO);

endmodule
